// File: rtl/flappy_pkg.sv
// Shared constants, pipe-word field layout, FSM states and pipe placement
// helpers for the flappy pipe scheduler.
package flappy_pkg;

    localparam logic [9:0]  SCREEN_W  = 10'd640;
    localparam logic [9:0]  PIPE_W    = 10'd50;
    localparam logic [9:0]  PIPE_HEAD = 10'd23;
    localparam logic [9:0]  Y_SPAN    = 10'd284;
    localparam logic [7:0]  GAP_MIN   = 8'd100;
    localparam logic [7:0]  GAP_SPAN  = 8'd50;

    // Pipe word layout: {4'b0, gap[7:0], x[9:0], y[9:0]}
    localparam int Y_LSB   = 0;
    localparam int X_LSB   = 10;
    localparam int GAP_LSB = 20;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Index 0..2 corresponds to pipe1..pipe3.
    localparam logic [2:0][9:0] X_INIT   = {10'd630, 10'd420, 10'd210};
    localparam logic [2:0][9:0] PIPE_OFF = {10'd191, 10'd97, 10'd0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    function automatic logic [9:0] pipe_y(input logic [15:0] r, input logic [9:0] off);
        return PIPE_HEAD + 10'(({1'b0, r} + {7'b0, off}) % {7'b0, Y_SPAN});
    endfunction

    function automatic logic [7:0] pipe_gap(input logic [15:0] r, input logic [9:0] off);
        return GAP_MIN + 8'(({1'b0, r} + {7'b0, off}) % {9'b0, GAP_SPAN});
    endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that loads its seed while rst is low.
module pipe_lfsr (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    input  logic        en,
    output logic [15:0] value
);

    logic feedback;

    assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

    always_ff @(posedge clk) begin
        if (!rst) begin
            value <= seed;
        end else if (en) begin
            value <= {value[14:0], feedback};
        end
    end

endmodule

// File: rtl/pipe_scheduler.sv
// Scrolls three pipes, respawns them with LFSR-derived height/gap and flags bird passes.
// Optional player-2 height nudging of the selected pipe: define PIPE_P2_ADJUST_EN.
module pipe_scheduler #(
    parameter int SPEED  = 2,
    parameter int BIRD_X = 80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic        fail,
    input  logic        adj_up,
    input  logic        adj_down,
    output logic [31:0] pipe1,
    output logic [31:0] pipe2,
    output logic [31:0] pipe3,
    output logic [1:0]  sel,
    output logic        pass,
    output logic [1:0]  state
);

    import flappy_pkg::*;

    localparam logic [9:0] STEP      = 10'(SPEED);
    localparam logic [9:0] BIRD_EDGE = 10'(BIRD_X);

    state_t           cur_state, next_state;
    logic [15:0]      lfsr;
    logic [2:0][9:0]  x_q, x_next, y_q, y_next;
    logic [2:0][7:0]  gap_q, gap_next;
    logic [1:0]       sel_q, sel_next;
    logic             pass_q, pass_hit, any_respawn;

    pipe_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .seed  (LFSR_SEED),
        .en    (1'b1),
        .value (lfsr)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (fail)  next_state = HALT;
            HALT:    if (start) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Candidate pipe positions for a RUN tick; respawn takes precedence over scroll and nudge.
    always_comb begin
        x_next      = x_q;
        y_next      = y_q;
        gap_next    = gap_q;
        sel_next    = sel_q;
        pass_hit    = 1'b0;
        any_respawn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (x_q[i] <= STEP) begin
                x_next[i]   = SCREEN_W;
                y_next[i]   = pipe_y(lfsr, PIPE_OFF[i]);
                gap_next[i] = pipe_gap(lfsr, PIPE_OFF[i]);
                sel_next    = 2'(i + 1);
                any_respawn = 1'b1;
            end else begin
                x_next[i] = x_q[i] - STEP;
                if ((x_q[i] + PIPE_W > BIRD_EDGE) && (x_next[i] + PIPE_W <= BIRD_EDGE)) begin
                    pass_hit = 1'b1;
                end
`ifdef PIPE_P2_ADJUST_EN
                if ((sel_q == 2'(i + 1)) && (adj_up ^ adj_down)) begin
                    if (adj_up && (y_q[i] > PIPE_HEAD)) begin
                        y_next[i] = y_q[i] - 10'd1;
                    end else if (adj_down && (y_q[i] < PIPE_HEAD + Y_SPAN - 10'd1)) begin
                        y_next[i] = y_q[i] + 10'd1;
                    end
                end
`endif
            end
        end
    end

`ifndef PIPE_P2_ADJUST_EN
    logic unused_adj;
    assign unused_adj = adj_up | adj_down;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q    <= X_INIT;
            sel_q  <= 2'd3;
            pass_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                y_q[i]   <= pipe_y(LFSR_SEED, PIPE_OFF[i]);
                gap_q[i] <= pipe_gap(LFSR_SEED, PIPE_OFF[i]);
            end
        end else begin
            pass_q <= 1'b0;
            case (cur_state)
                IDLE: begin
                    x_q <= X_INIT;
                    for (int i = 0; i < 3; i++) begin
                        y_q[i]   <= pipe_y(lfsr, PIPE_OFF[i]);
                        gap_q[i] <= pipe_gap(lfsr, PIPE_OFF[i]);
                    end
                end
                RUN: begin
                    if (tick && !fail) begin
                        x_q    <= x_next;
                        y_q    <= y_next;
                        gap_q  <= gap_next;
                        sel_q  <= sel_next;
                        pass_q <= pass_hit && !any_respawn;
                    end
                end
                HALT: begin
                    if (start) x_q <= X_INIT;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pipe1 = '0;
        pipe2 = '0;
        pipe3 = '0;
        pipe1[GAP_LSB +: 8] = gap_q[0];
        pipe1[X_LSB +: 10]  = x_q[0];
        pipe1[Y_LSB +: 10]  = y_q[0];
        pipe2[GAP_LSB +: 8] = gap_q[1];
        pipe2[X_LSB +: 10]  = x_q[1];
        pipe2[Y_LSB +: 10]  = y_q[1];
        pipe3[GAP_LSB +: 8] = gap_q[2];
        pipe3[X_LSB +: 10]  = x_q[2];
        pipe3[Y_LSB +: 10]  = y_q[2];
    end

    assign sel   = sel_q;
    assign pass  = pass_q;
    assign state = cur_state;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed plus randomized bench for pipe_scheduler against a rule-level reference model.
module tb_pipe_scheduler;

    localparam int SPEED  = 2;
    localparam int BIRD_X = 80;

    logic        clk = 1'b0;
    logic        rst, tick, start, fail, adj_up, adj_down;
    logic [31:0] pipe1, pipe2, pipe3;
    logic [1:0]  sel, state;
    logic        pass;

    int checks = 0;
    int errors = 0;

    int m_state, m_lfsr, m_sel;
    int m_x[3], m_y[3], m_gap[3];
    bit m_pass;
    int off_tab[3] = '{0, 97, 191};

    always #5 clk = ~clk;

    pipe_scheduler #(.SPEED(SPEED), .BIRD_X(BIRD_X)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .start    (start),
        .fail     (fail),
        .adj_up   (adj_up),
        .adj_down (adj_down),
        .pipe1    (pipe1),
        .pipe2    (pipe2),
        .pipe3    (pipe3),
        .sel      (sel),
        .pass     (pass),
        .state    (state)
    );

    function automatic int lfsrNext(input int l);
        int fb;
        fb = $countones(l & 32'h0000B400) & 1;
        return ((l << 1) | fb) & 32'h0000FFFF;
    endfunction

    function automatic int modelY(input int l, input int off);
        return 23 + ((l + off) % 284);
    endfunction

    function automatic int modelGap(input int l, input int off);
        return 100 + ((l + off) % 50);
    endfunction

    function automatic logic [31:0] fieldX(input logic [31:0] w);
        return {22'b0, w[19:10]};
    endfunction

    function automatic logic [31:0] fieldY(input logic [31:0] w);
        return {22'b0, w[9:0]};
    endfunction

    function automatic logic [31:0] fieldGap(input logic [31:0] w);
        return {24'b0, w[27:20]};
    endfunction

    function automatic logic [31:0] packWord(input int g, input int x, input int y);
        return {4'b0, 8'(g), 10'(x), 10'(y)};
    endfunction

    task automatic modelStep(input bit r, input bit t, input bit s, input bit f, input bit u, input bit d);
        int  old_lfsr, old_sel, nx;
        bit  any_resp, hit;
        if (!r) begin
            m_state = 0;
            m_lfsr  = 32'h0000ACE1;
            m_sel   = 3;
            m_pass  = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_x[i]   = 210 * (i + 1);
                m_y[i]   = modelY(32'h0000ACE1, off_tab[i]);
                m_gap[i] = modelGap(32'h0000ACE1, off_tab[i]);
            end
            return;
        end
        old_lfsr = m_lfsr;
        old_sel  = m_sel;
        m_pass   = 1'b0;
        case (m_state)
            0: begin
                for (int i = 0; i < 3; i++) begin
                    m_x[i]   = 210 * (i + 1);
                    m_y[i]   = modelY(old_lfsr, off_tab[i]);
                    m_gap[i] = modelGap(old_lfsr, off_tab[i]);
                end
                if (s) m_state = 1;
            end
            1: begin
                if (f) begin
                    m_state = 2;
                end else if (t) begin
                    any_resp = 1'b0;
                    hit      = 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        if (m_x[i] <= SPEED) begin
                            m_x[i]   = 640;
                            m_y[i]   = modelY(old_lfsr, off_tab[i]);
                            m_gap[i] = modelGap(old_lfsr, off_tab[i]);
                            m_sel    = i + 1;
                            any_resp = 1'b1;
                        end else begin
                            nx = m_x[i] - SPEED;
                            if ((m_x[i] + 50 > BIRD_X) && (nx + 50 <= BIRD_X)) hit = 1'b1;
                            m_x[i] = nx;
`ifdef PIPE_P2_ADJUST_EN
                            if ((old_sel == i + 1) && (u != d)) begin
                                if (u && m_y[i] > 23) m_y[i] = m_y[i] - 1;
                                else if (d && m_y[i] < 306) m_y[i] = m_y[i] + 1;
                            end
`endif
                        end
                    end
                    m_pass = hit && !any_resp;
                end
            end
            default: begin
                if (s) begin
                    m_state = 0;
                    for (int i = 0; i < 3; i++) m_x[i] = 210 * (i + 1);
                end
            end
        endcase
        m_lfsr = lfsrNext(old_lfsr);
        if (u && d && old_sel == 0) m_sel = old_sel;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".state"}, {30'b0, state}, 32'(m_state));
        checkOutput({tag, ".sel"},   {30'b0, sel},   32'(m_sel));
        checkOutput({tag, ".pass"},  {31'b0, pass},  {31'b0, m_pass});
        checkOutput({tag, ".pipe1"}, pipe1, packWord(m_gap[0], m_x[0], m_y[0]));
        checkOutput({tag, ".pipe2"}, pipe2, packWord(m_gap[1], m_x[1], m_y[1]));
        checkOutput({tag, ".pipe3"}, pipe3, packWord(m_gap[2], m_x[2], m_y[2]));
    endtask

    task automatic applyStimulus(input bit r, input bit t, input bit s, input bit f, input bit u, input bit d);
        rst      = r;
        tick     = t;
        start    = s;
        fail     = f;
        adj_up   = u;
        adj_down = d;
        @(posedge clk);
        modelStep(r, t, s, f, u, d);
        #1;
    endtask

    initial begin
        int y_save, xs0, xs1, xs2, yv, gv;
        bit r, t, s, f, u, d;

        rst = 1'b0; tick = 1'b0; start = 1'b0; fail = 1'b0; adj_up = 1'b0; adj_down = 1'b0;

        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 1, 0);
        checkModel("reset");
        checkOutput("reset.state", {30'b0, state}, 32'd0);
        checkOutput("reset.x1", fieldX(pipe1), 32'd210);
        checkOutput("reset.x2", fieldX(pipe2), 32'd420);
        checkOutput("reset.x3", fieldX(pipe3), 32'd630);
        checkOutput("reset.sel", {30'b0, sel}, 32'd3);
        checkOutput("reset.pass", {31'b0, pass}, 32'd0);

        applyStimulus(1, 1, 0, 0, 0, 0);
        checkModel("idle_tick");
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkModel("start");
        checkOutput("start.state", {30'b0, state}, 32'd1);

        for (int k = 1; k <= 105; k++) begin
            y_save = m_y[0];
            applyStimulus(1, 1, 0, 0, 0, 0);
            checkModel($sformatf("tick%0d", k));
            if (k == 1) begin
                checkOutput("move.x1", fieldX(pipe1), 32'd208);
                checkOutput("move.x2", fieldX(pipe2), 32'd418);
                checkOutput("move.x3", fieldX(pipe3), 32'd628);
                checkOutput("move.y1", fieldY(pipe1), 32'(y_save));
            end
            if (k == 89) begin
                checkOutput("pass89.x1", fieldX(pipe1), 32'd32);
                checkOutput("pass89.pass", {31'b0, pass}, 32'd0);
            end
            if (k == 90) begin
                checkOutput("pass90.x1", fieldX(pipe1), 32'd30);
                checkOutput("pass90.pass", {31'b0, pass}, 32'd1);
            end
            if (k == 104) checkOutput("respawn104.x1", fieldX(pipe1), 32'd2);
            if (k == 105) begin
                yv = int'(fieldY(pipe1));
                gv = int'(fieldGap(pipe1));
                checkOutput("respawn.x1", fieldX(pipe1), 32'd640);
                checkOutput("respawn.sel", {30'b0, sel}, 32'd1);
                checkOutput("respawn.y_range", {31'b0, (yv >= 23 && yv <= 306)}, 32'd1);
                checkOutput("respawn.gap_range", {31'b0, (gv >= 100 && gv <= 149)}, 32'd1);
            end
            applyStimulus(1, 0, 0, 0, 0, 0);
            checkModel($sformatf("gap%0d", k));
            if (k == 90) checkOutput("pass.one_cycle", {31'b0, pass}, 32'd0);
        end

        y_save = m_y[0];
        applyStimulus(1, 1, 1, 0, 1, 0);
        checkModel("adj_up");
`ifndef PIPE_P2_ADJUST_EN
        checkOutput("adj_up.y1", fieldY(pipe1), 32'(y_save));
`endif
        applyStimulus(1, 1, 0, 0, 0, 1);
        checkModel("adj_down");
`ifndef PIPE_P2_ADJUST_EN
        checkOutput("adj_down.y1", fieldY(pipe1), 32'(y_save));
`endif
        y_save = m_y[0];
        applyStimulus(1, 1, 0, 0, 1, 1);
        checkModel("adj_both");
        checkOutput("adj_both.y1", fieldY(pipe1), 32'(y_save));

        xs0 = m_x[0]; xs1 = m_x[1]; xs2 = m_x[2];
        applyStimulus(1, 1, 0, 1, 0, 0);
        checkModel("fail");
        checkOutput("fail.state", {30'b0, state}, 32'd2);
        checkOutput("fail.x1", fieldX(pipe1), 32'(xs0));
        for (int j = 0; j < 10; j++) begin
            applyStimulus(1, 1, 0, 0, 1, 0);
            checkOutput($sformatf("halt%0d.x1", j), fieldX(pipe1), 32'(xs0));
            checkOutput($sformatf("halt%0d.x2", j), fieldX(pipe2), 32'(xs1));
            checkOutput($sformatf("halt%0d.x3", j), fieldX(pipe3), 32'(xs2));
        end
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkModel("unhalt");
        checkOutput("unhalt.state", {30'b0, state}, 32'd0);
        checkOutput("unhalt.x1", fieldX(pipe1), 32'd210);
        checkOutput("unhalt.x2", fieldX(pipe2), 32'd420);
        checkOutput("unhalt.x3", fieldX(pipe3), 32'd630);

        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 999) != 0);
            t = ($urandom_range(0, 1) == 1);
            s = ($urandom_range(0, 24) == 0);
            f = ($urandom_range(0, 399) == 0);
            u = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 3) == 0);
            applyStimulus(r, t, s, f, u, d);
            checkModel("rand");
        end

        applyStimulus(1, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
